// File: rtl/wb_select_stage_pkg.sv
// Shared definitions for the writeback-select stage: source-select and load
// funct3 encodings plus the buffered entry payload.
package wb_select_stage_pkg;

  localparam int WB_XLEN_MAX = 64;
  localparam int WB_RD_MAX   = 8;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Sized for the widest configuration; narrower builds use the low bits.
  typedef struct packed {
    logic [WB_XLEN_MAX-1:0] data;
    logic [WB_RD_MAX-1:0]   rd;
    logic                   we;
    logic                   misalign;
  } wb_entry_t;

endpackage

// File: rtl/wb_select_stage_load_align_ext.sv
// Combinational load-lane extraction, sign/zero extension and misalignment
// detection for a raw aligned memory word.
module load_align_ext
  import wb_select_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  assign w_byte = i_mem_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{i_offset[1], 4'b0000} +: 16];
  assign w_word = i_mem_rdata[31:0];

  always_comb begin
    o_data     = XLEN'(signed'(w_word));
    o_misalign = (i_offset != 2'b00);
    case (i_funct3)
      F3_LB: begin
        o_data     = XLEN'(signed'(w_byte));
        o_misalign = 1'b0;
      end
      F3_LBU: begin
        o_data     = XLEN'(w_byte);
        o_misalign = 1'b0;
      end
      F3_LH: begin
        o_data     = XLEN'(signed'(w_half));
        o_misalign = i_offset[0];
      end
      F3_LHU: begin
        o_data     = XLEN'(w_half);
        o_misalign = i_offset[0];
      end
      default: ; // LW and unlisted codes share the word path
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Registered N-way writeback selector with a 2-entry skid FIFO.
// Define WB_LOAD_EXT_EN to enable load extraction, extension and misalign checks.
module wb_select_stage
  import wb_select_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb_sel,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   imm,
  input  logic [2:0]        ld_funct3,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we,
  output logic              wb_misalign
);

  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_misalign;

`ifdef WB_LOAD_EXT_EN
  load_align_ext #(.XLEN(XLEN)) u_load_align_ext (
    .i_mem_rdata (mem_rdata),
    .i_offset    (alu_res[1:0]),
    .i_funct3    (ld_funct3),
    .o_data      (w_ld_data),
    .o_misalign  (w_ld_misalign)
  );
`else
  assign w_ld_data     = mem_rdata;
  assign w_ld_misalign = 1'b0;
`endif

  logic [XLEN-1:0] w_sel_data;
  logic            w_misalign;
  wb_entry_t       w_entry;

  always_comb begin
    w_sel_data = alu_res;
    case (wb_sel_e'(wb_sel))
      WB_ALU: w_sel_data = alu_res;
      WB_MEM: w_sel_data = w_ld_data;
      WB_PC4: w_sel_data = pc_plus4;
      WB_IMM: w_sel_data = imm;
      default: w_sel_data = alu_res;
    endcase
  end

  assign w_misalign       = (wb_sel_e'(wb_sel) == WB_MEM) && w_ld_misalign;
  assign w_entry.data     = WB_XLEN_MAX'(w_sel_data);
  assign w_entry.rd       = WB_RD_MAX'(rd);
  assign w_entry.we       = reg_write && (rd != '0) && !w_misalign;
  assign w_entry.misalign = w_misalign;

  wb_entry_t  r_mem [0:1];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // in_ready comes only from the registered count, never from out_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  wb_entry_t w_head;
  assign w_head      = r_mem[r_rd_ptr];
  assign wb_data     = w_head.data[XLEN-1:0];
  assign wb_rd       = w_head.rd[REG_AW-1:0];
  assign wb_we       = w_head.we;
  assign wb_misalign = w_head.misalign;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed self-checking bench for wb_select_stage (XLEN = 32, REG_AW = 5).
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wb_sel;
  logic [31:0] alu_res;
  logic [31:0] mem_rdata;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic [2:0]  ld_funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        wb_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_select_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wb_sel     (wb_sel),
    .alu_res    (alu_res),
    .mem_rdata  (mem_rdata),
    .pc_plus4   (pc_plus4),
    .imm        (imm),
    .ld_funct3  (ld_funct3),
    .rd         (rd),
    .reg_write  (reg_write),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .wb_misalign(wb_misalign)
  );

  task automatic set_inputs(input logic [1:0] sel, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [2:0] f3,
                            input logic [4:0] dst, input logic we);
    wb_sel    = sel;
    alu_res   = alu;
    mem_rdata = mem;
    ld_funct3 = f3;
    rd        = dst;
    reg_write = we;
  endtask

  // One accepted entry with out_ready high; returns #1 after the accepting edge.
  task automatic send_one(input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [2:0] f3,
                          input logic [4:0] dst, input logic we);
    set_inputs(sel, alu, mem, f3, dst, we);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    set_inputs(2'd0, 32'hFFFF_FFFF, 32'h0, 3'b010, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_data !== 32'h0 || wb_we !== 1'b0 ||
          wb_rd !== 5'd0 || wb_misalign !== 1'b0)
        $display("FAIL reset[%0d]: got ov=%b ir=%b data=%h we=%b rd=%0d mis=%b, want ov=0 ir=1 data=0 we=0 rd=0 mis=0",
                 i, out_valid, in_ready, wb_data, wb_we, wb_rd, wb_misalign);
      else begin
        n_pass++;
        $display("reset[%0d] ok", i);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_select;
    out_ready = 1'b1;
    send_one(2'd0, 32'h0, 32'h1, 3'b010, 5'd1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'h0 || wb_rd !== 5'd1)
      $display("FAIL basic_alu: got ov=%b data=%h rd=%0d, want ov=1 data=00000000 rd=1", out_valid, wb_data, wb_rd);
    else begin n_pass++; $display("basic_alu data=%h", wb_data); end
    send_one(2'd1, 32'h0, 32'h1, 3'b010, 5'd2, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'h1 || wb_rd !== 5'd2 || wb_we !== 1'b1)
      $display("FAIL basic_mem: got ov=%b data=%h rd=%0d we=%b, want ov=1 data=00000001 rd=2 we=1",
               out_valid, wb_data, wb_rd, wb_we);
    else begin n_pass++; $display("basic_mem data=%h", wb_data); end
    send_one(2'd2, 32'h0, 32'h1, 3'b010, 5'd3, 1'b1);
    pc_plus4 = 32'h0; // already captured; proves payload need not stay stable
    n_checks++;
    if (wb_data !== 32'h0000_0104)
      $display("FAIL basic_pc4: got data=%h, want 00000104", wb_data);
    else begin n_pass++; $display("basic_pc4 data=%h", wb_data); end
    send_one(2'd3, 32'h0, 32'h1, 3'b010, 5'd5, 1'b0);
    n_checks++;
    if (wb_data !== 32'hABCD_E000 || wb_we !== 1'b0)
      $display("FAIL basic_imm: got data=%h we=%b, want data=abcde000 we=0", wb_data, wb_we);
    else begin n_pass++; $display("basic_imm data=%h we=%b", wb_data, wb_we); end
    drain();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_empty: got ov=%b, want 0", out_valid);
    else begin n_pass++; $display("basic_empty ok"); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3_tab  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] off_tab [4] = '{32'h3, 32'h3, 32'h2, 32'h2};
`ifdef WB_LOAD_EXT_EN
    logic [31:0] exp_tab [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
`else
    logic [31:0] exp_tab [4] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_one(2'd1, off_tab[i], 32'h80FF_7F01, f3_tab[i], 5'd5, 1'b1);
      n_checks++;
      if (wb_data !== exp_tab[i] || wb_we !== 1'b1 || wb_misalign !== 1'b0)
        $display("FAIL load_ext[f3=%b]: got data=%h we=%b mis=%b, want data=%h we=1 mis=0",
                 f3_tab[i], wb_data, wb_we, wb_misalign, exp_tab[i]);
      else begin n_pass++; $display("load_ext f3=%b data=%h", f3_tab[i], wb_data); end
    end
    drain();
  endtask

  task automatic test_misalign;
    logic exp_mis;
    logic exp_we;
`ifdef WB_LOAD_EXT_EN
    exp_mis = 1'b1; exp_we = 1'b0;
`else
    exp_mis = 1'b0; exp_we = 1'b1;
`endif
    out_ready = 1'b1;
    send_one(2'd1, 32'h0000_0102, 32'hDEAD_BEEF, 3'b010, 5'd7, 1'b1);
    n_checks++;
    if (wb_misalign !== exp_mis || wb_we !== exp_we || wb_data !== 32'hDEAD_BEEF)
      $display("FAIL misalign_lw: got mis=%b we=%b data=%h, want mis=%b we=%b data=deadbeef",
               wb_misalign, wb_we, wb_data, exp_mis, exp_we);
    else begin n_pass++; $display("misalign_lw mis=%b we=%b", wb_misalign, wb_we); end
    // Same offset on an ALU result is not a load and must not flag.
    send_one(2'd0, 32'h0000_0102, 32'hDEAD_BEEF, 3'b010, 5'd7, 1'b1);
    n_checks++;
    if (wb_misalign !== 1'b0 || wb_we !== 1'b1 || wb_data !== 32'h0000_0102)
      $display("FAIL misalign_alu: got mis=%b we=%b data=%h, want mis=0 we=1 data=00000102",
               wb_misalign, wb_we, wb_data);
    else begin n_pass++; $display("misalign_alu ok"); end
    drain();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_inputs(2'd0, 32'h11, 32'h0, 3'b010, 5'd1, 1'b1);
    @(posedge clk); #1;
    set_inputs(2'd0, 32'h22, 32'h0, 3'b010, 5'd2, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || wb_data !== 32'h11)
      $display("FAIL bp_full: got ir=%b ov=%b data=%h, want ir=0 ov=1 data=00000011", in_ready, out_valid, wb_data);
    else begin n_pass++; $display("bp_full ok"); end
    set_inputs(2'd0, 32'h33, 32'h0, 3'b010, 5'd3, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || wb_data !== 32'h11 || wb_rd !== 5'd1)
      $display("FAIL bp_hold: got ir=%b data=%h rd=%0d, want ir=0 data=00000011 rd=1", in_ready, wb_data, wb_rd);
    else begin n_pass++; $display("bp_hold ok"); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || wb_data !== 32'h22 || wb_rd !== 5'd2)
      $display("FAIL bp_pop1: got ir=%b data=%h rd=%0d, want ir=1 data=00000022 rd=2", in_ready, wb_data, wb_rd);
    else begin n_pass++; $display("bp_pop1 ok"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || wb_data !== 32'h33 || wb_rd !== 5'd3)
      $display("FAIL bp_pop2: got ov=%b data=%h rd=%0d, want ov=1 data=00000033 rd=3", out_valid, wb_data, wb_rd);
    else begin n_pass++; $display("bp_pop2 ok"); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_empty: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    else begin n_pass++; $display("bp_empty ok"); end
  endtask

  task automatic test_x0;
    out_ready = 1'b1;
    send_one(2'd0, 32'h1234, 32'h0, 3'b010, 5'd0, 1'b1);
    n_checks++;
    if (wb_data !== 32'h1234 || wb_we !== 1'b0 || wb_rd !== 5'd0)
      $display("FAIL x0: got data=%h we=%b rd=%0d, want data=00001234 we=0 rd=0", wb_data, wb_we, wb_rd);
    else begin n_pass++; $display("x0 data=%h we=%b", wb_data, wb_we); end
    drain();
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    send_one(2'd0, 32'h55, 32'h0, 3'b010, 5'd9, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_data !== 32'h0 || wb_we !== 1'b0)
      $display("FAIL mid_reset: got ov=%b ir=%b data=%h we=%b, want ov=0 ir=1 data=0 we=0",
               out_valid, in_ready, wb_data, wb_we);
    else begin n_pass++; $display("mid_reset ok"); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pc_plus4  = 32'h0000_0104;
    imm       = 32'hABCD_E000;
    set_inputs(2'd0, 32'h0, 32'h0, 3'b010, 5'd0, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_basic_select();
    test_load_ext();
    test_misalign();
    test_back_to_back();
    test_x0();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
